// File: rtl/instr_arb_pkg.sv
// Shared types and helpers for the round-robin instruction arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package instr_arb_pkg;

    // Arbiter state: free round-robin arbitration or held on a branch owner
    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Channel index width; a single channel still needs one bit of index
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Lowest bit position of channel idx inside a packed per-channel bus
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/instr_arbiter_rr_rr_picker.sv
// Rotating-priority one-hot selector: first requester after ptr wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_picker
    import instr_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W  = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] idx;
    logic            found;

    // Scan ptr+1, ptr+2, ... wrapping, so the last winner has lowest priority
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/instr_arbiter_rr.sv
// Round-robin command arbiter with branch lock feeding one registered output stage.
// Latency: an accepted beat appears on out_* one clk after acceptance; 1 beat/cycle.
// Backpressure: out_valid & ~out_ready freezes output, pointer and state; in_ready drops to 0.
module instr_arbiter_rr
    import instr_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    localparam int CH_W  = ch_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH*ADDR_W-1:0] in_addr,
    input  logic [NUM_CH-1:0]        in_lock,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [CH_W-1:0]          out_ch,
    output logic                     locked
);

    arb_state_t         state;
    logic [CH_W-1:0]    ptr;
    logic [CH_W-1:0]    lock_ch;

    logic [NUM_CH-1:0]  pick_grant;
    logic [CH_W-1:0]    pick_idx;
    logic [NUM_CH-1:0]  lock_oh;
    logic [NUM_CH-1:0]  grant;
    logic [CH_W-1:0]    sel_idx;
    logic [DATA_W-1:0]  sel_data;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_lock;
    logic               load_en;
    logic               accept;

    rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    // Output slot is free when empty or being drained this cycle
    assign load_en = ~out_valid | out_ready;

    // Winner: picker result while arbitrating, the lock owner (if it has a beat) while locked
    always_comb begin
        lock_oh          = '0;
        lock_oh[lock_ch] = 1'b1;
        if (state == ST_LOCKED) begin
            grant   = lock_oh & in_valid;
            sel_idx = lock_ch;
        end else begin
            grant   = pick_grant;
            sel_idx = pick_idx;
        end
    end

    assign in_ready = {NUM_CH{load_en & ~reset}} & grant;
    assign accept   = |(in_valid & in_ready);
    assign locked   = (state == ST_LOCKED);

    // Steer the winning channel's command, address and lock flag
    always_comb begin
        sel_data = '0;
        sel_addr = '0;
        sel_lock = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_idx == CH_W'(i)) begin
                sel_data = in_data[slice_lsb(i, DATA_W) +: DATA_W];
                sel_addr = in_addr[slice_lsb(i, ADDR_W) +: ADDR_W];
                sel_lock = in_lock[i];
            end
        end
    end

    // Lock FSM, fairness pointer and output register; all advance only on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ARB;
            ptr       <= CH_W'(NUM_CH - 1);
            lock_ch   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_ch    <= '0;
        end else begin
            if (load_en) begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= sel_data;
                    out_addr <= sel_addr;
                    out_ch   <= sel_idx;
                end
            end
            if (accept) begin
                case (state)
                    ST_ARB: begin
                        ptr <= sel_idx;
                        if (sel_lock) begin
                            state   <= ST_LOCKED;
                            lock_ch <= sel_idx;
                        end
                    end
                    ST_LOCKED: begin
                        // Releasing the lock restarts the rotation just after the owner
                        if (!sel_lock) begin
                            state <= ST_ARB;
                            ptr   <= lock_ch;
                        end
                    end
                    default: state <= ST_ARB;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_arbiter_rr.sv
// Directed bench for the round-robin arbiter: vector table plus reset-in-lock sequence.
// Latency: checks in_ready mid-cycle and out_* one edge after the driven beat.
// Backpressure: exercised through out_ready in the vector table.
module tb_instr_arbiter_rr;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic                     clk;
    logic                     reset;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH*ADDR_W-1:0] in_addr;
    logic [NUM_CH-1:0]        in_lock;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [ADDR_W-1:0]        out_addr;
    logic [1:0]               out_ch;
    logic                     locked;

    instr_arbiter_rr #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_lock   (in_lock),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_ch    (out_ch),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] lck;
        logic       ordy;
        logic [3:0] erdy;
        logic       eov;
        logic [1:0] ech;
        logic       elk;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] data_pat [NUM_CH];
    logic [31:0] addr_pat [NUM_CH];
    int          checks;
    int          errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] l, input logic o,
                       input logic [3:0] r, input logic ov, input logic [1:0] ch, input logic lk);
        vec_t t;
        t.vld  = v;
        t.lck  = l;
        t.ordy = o;
        t.erdy = r;
        t.eov  = ov;
        t.ech  = ch;
        t.elk  = lk;
        vecs.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        data_pat  = '{32'h1111_0000, 32'hDEAD_BEEF, 32'h00A0_0093, 32'h3333_0003};
        addr_pat  = '{32'h0000_0040, 32'h0000_0080, 32'h0000_0100, 32'h0000_0200};
        for (int i = 0; i < NUM_CH; i++) begin
            in_data[i*DATA_W +: DATA_W] = data_pat[i];
            in_addr[i*ADDR_W +: ADDR_W] = addr_pat[i];
        end

        // valid, lock, out_ready | expected in_ready, out_valid, out_ch, locked
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0); // idle after reset
        add(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0); // first single request ch2
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0); // drained
        add(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0); // ptr -> 3
        add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0); // round robin 0..3,0,1
        add(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0);
        add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0); // backpressure x3, ch1 held
        add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
        add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
        add(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0); // release -> ch2
        add(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0);
        add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1); // ch1 takes the lock
        add(4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1); // lock beats 1,1,0
        add(4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1);
        add(4'b1111, 4'b1101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0); // others' lock ignored
        add(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0); // after unlock -> ch2
        add(4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1); // ch3 takes the lock
        add(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1); // owner idle x5
        add(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1);
        add(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1);
        add(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1);
        add(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1);
        add(4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0); // owner resumes, unlocks
        add(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1); // ch1 locks

        // Reset state, with requests pending
        reset     = 1'b1;
        in_valid  = 4'b1111;
        in_lock   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'h0);
        check("reset out_valid", 64'(out_valid), 64'h0);
        check("reset locked", 64'(locked), 64'h0);
        check("reset out_data", 64'(out_data), 64'h0);
        check("reset out_ch", 64'(out_ch), 64'h0);
        @(negedge clk);
        in_valid = '0;
        reset    = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid  = vecs[i].vld;
            in_lock   = vecs[i].lck;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].erdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].eov));
            check($sformatf("v%0d locked", i), 64'(locked), 64'(vecs[i].elk));
            if (vecs[i].eov) begin
                check($sformatf("v%0d out_ch", i), 64'(out_ch), 64'(vecs[i].ech));
                check($sformatf("v%0d out_data", i), 64'(out_data), 64'(data_pat[vecs[i].ech]));
                check($sformatf("v%0d out_addr", i), 64'(out_addr), 64'(addr_pat[vecs[i].ech]));
            end
        end

        // Stall while locked on ch1, then reset asynchronously mid-cycle
        @(negedge clk);
        in_valid  = 4'b1111;
        in_lock   = 4'b0000;
        out_ready = 1'b0;
        #1;
        check("stall_locked in_ready", 64'(in_ready), 64'h0);
        @(posedge clk);
        #1;
        check("stall_locked out_valid", 64'(out_valid), 64'h1);
        check("stall_locked locked", 64'(locked), 64'h1);
        check("stall_locked out_data", 64'(out_data), 64'hDEAD_BEEF);
        reset = 1'b1;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'h0);
        check("midreset locked", 64'(locked), 64'h0);
        check("midreset in_ready", 64'(in_ready), 64'h0);
        check("midreset out_data", 64'(out_data), 64'h0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("postreset in_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;
        check("postreset out_valid", 64'(out_valid), 64'h1);
        check("postreset out_ch", 64'(out_ch), 64'h0);
        check("postreset out_data", 64'(out_data), 64'(data_pat[0]));
        check("postreset locked", 64'(locked), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
